// File: rtl/pc_pkg.sv
// pc_pkg: shared op encodings and stack-pointer sizing for the PC/return-stack unit.
package pc_pkg;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_INC  = 3'b001;
    localparam logic [2:0] OP_JMP  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    function automatic int sp_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_stack_unit_if.sv
// pc_stack_unit_if: decoder-side controls and PC/status returned to the fetch path.
interface pc_stack_unit_if #(parameter int ADDR_W = 4);

    logic              en;
    logic [2:0]        op;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc;
    logic              stack_empty;
    logic              stack_full;
    logic              err;

    modport master (output en, op, target, input pc, stack_empty, stack_full, err);
    modport slave  (input en, op, target, output pc, stack_empty, stack_full, err);

endinterface

// File: rtl/ras_lifo.sv
// ras_lifo: return-address LIFO with registered empty/full flags derived from next-state sp.
module ras_lifo
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              empty,
    output logic              full
);

    localparam int SP_W  = sp_width(STACK_DEPTH);
    localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1;

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [SP_W-1:0]   sp, sp_nxt, top_sp;
    logic [IDX_W-1:0]  wr_idx, rd_idx;

    always_comb begin
        sp_nxt = push ? sp + 1'b1 : pop ? sp - 1'b1 : sp;
        top_sp = (sp == '0) ? '0 : sp - 1'b1;
        wr_idx = sp[IDX_W-1:0];
        rd_idx = top_sp[IDX_W-1:0];
        top    = mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp    <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            sp    <= sp_nxt;
            empty <= sp_nxt == '0;
            full  <= sp_nxt == SP_W'(STACK_DEPTH);
        end
    end

    // Entries are never reset; only sp decides what is visible.
    always_ff @(posedge clk) begin
        if (!rst && push) mem[wr_idx] <= din;
    end

endmodule

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: program counter with next-PC mux, sticky fault flag and return-address stack.
module pc_stack_unit
    import pc_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int STACK_DEPTH = 4
) (
    input logic                clk,
    input logic                rst,
    pc_stack_unit_if.slave     bus
);

    logic [ADDR_W-1:0] pc_inc, pc_nxt, top;
    logic              is_call, is_ret, push, pop, fault, empty, full;

    always_comb begin
        pc_inc  = bus.pc + 1'b1;
        is_call = bus.op == OP_CALL;
        is_ret  = bus.op == OP_RET;
        push    = bus.en && is_call && !full;
        pop     = bus.en && is_ret && !empty;
        fault   = bus.en && ((is_call && full) || (is_ret && empty) || bus.op > OP_RET);
        pc_nxt  = !bus.en              ? bus.pc :
                  bus.op == OP_INC     ? pc_inc :
                  bus.op == OP_JMP     ? bus.target :
                  is_call              ? (full ? pc_inc : bus.target) :
                  is_ret               ? (empty ? pc_inc : top) : bus.pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.pc  <= '0;
            bus.err <= 1'b0;
        end else begin
            bus.pc  <= pc_nxt;
            bus.err <= bus.err | fault;
        end
    end

    ras_lifo #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .top   (top),
        .empty (empty),
        .full  (full)
    );

    assign bus.stack_empty = empty;
    assign bus.stack_full  = full;

endmodule

// File: tb/tb_pc_stack_unit.sv
// tb_pc_stack_unit: directed plan plus random ops against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int AW = 4;
    localparam int SD = 2;
    localparam int N  = 1 << AW;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    int   m_pc;
    bit   m_err;
    int   stk[$];

    pc_stack_unit_if #(.ADDR_W(AW)) bus ();

    pc_stack_unit #(.ADDR_W(AW), .STACK_DEPTH(SD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input bit r, input bit e, input int o, input int t);
        rst        = r;
        bus.en     = e;
        bus.op     = 3'(o);
        bus.target = AW'(t);
        @(posedge clk);
        if (r) begin
            m_pc = 0;
            m_err = 0;
            stk.delete();
        end else if (e) begin
            case (o)
                0: ;
                1: m_pc = (m_pc + 1) % N;
                2: m_pc = t;
                3: if (stk.size() < SD) begin
                       stk.push_back((m_pc + 1) % N);
                       m_pc = t;
                   end else begin
                       m_pc = (m_pc + 1) % N;
                       m_err = 1;
                   end
                4: if (stk.size() > 0) m_pc = stk.pop_back();
                   else begin
                       m_pc = (m_pc + 1) % N;
                       m_err = 1;
                   end
                default: m_err = 1;
            endcase
        end
        #1;
        check("pc", int'(bus.pc), m_pc);
        check("empty", int'(bus.stack_empty), int'(stk.size() == 0));
        check("full", int'(bus.stack_full), int'(stk.size() == SD));
        check("err", int'(bus.err), int'(m_err));
    endtask

    initial begin
        m_pc = 0;
        m_err = 0;
        cycle(1, 0, 0, 0);
        check("rst_pc", int'(bus.pc), 0);
        for (int i = 0; i < 17; i++) cycle(0, 1, 1, 0);
        check("wrap_pc", int'(bus.pc), 1);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 3, 9);
        check("call_pc", int'(bus.pc), 9);
        cycle(0, 1, 4, 0);
        check("ret_pc", int'(bus.pc), 4);
        cycle(0, 1, 2, 1);
        cycle(0, 1, 3, 5);
        cycle(0, 1, 3, 12);
        check("nest_full", int'(bus.stack_full), 1);
        cycle(0, 1, 3, 7);
        check("ovf_pc", int'(bus.pc), 13);
        cycle(0, 1, 4, 0);
        check("ret1_pc", int'(bus.pc), 6);
        cycle(0, 1, 4, 0);
        check("ret2_pc", int'(bus.pc), 2);
        cycle(1, 1, 1, 0);
        cycle(0, 1, 4, 0);
        check("udf_err", int'(bus.err), 1);
        cycle(0, 1, 6, 0);
        check("rsv_pc", int'(bus.pc), 1);
        cycle(1, 0, 0, 0);
        cycle(0, 0, 2, 10);
        cycle(0, 0, 3, 3);
        cycle(0, 0, 7, 0);
        check("en0_err", int'(bus.err), 0);
        cycle(0, 1, 2, 10);
        check("jmp_pc", int'(bus.pc), 10);
        cycle(0, 1, 2, 15);
        cycle(0, 1, 3, 2);
        cycle(1, 1, 4, 0);
        cycle(0, 1, 4, 0);
        check("discard_err", int'(bus.err), 1);
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) != 0,
                  $urandom_range(0, 9) < 8 ? int'($urandom_range(0, 4)) : int'($urandom_range(5, 7)),
                  int'($urandom_range(0, N - 1)));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
